// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared constants for the ID/EX stage
// Purpose: default widths, the bubble encoding and the memory opcodes.
// Ports: none (package).
package id_ex_stage_pkg;

    localparam int N_DEF = 16;
    localparam int R_DEF = 3;

    localparam logic [4:0] OP_NOP = 5'b00001;
    localparam logic [4:0] OP_LD  = 5'b10001;
    localparam logic [4:0] OP_ST  = 5'b10000;
    localparam logic [4:0] OP_STU = 5'b10011;

    // Bubble instruction: NOP opcode, all other fields zero.
    localparam logic [15:0] NOP_INSTR = {OP_NOP, 11'h000};

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// rtl/id_ex_stage_fwd_mux.sv - operand forwarding select for one source
// Purpose: choose between the registered read data, the EX/MEM result and
//          the MEM/WB result for a single source specifier.
// Ports:
//   i_used                   source is actually read by the instruction
//   i_src                    source register specifier
//   i_reg_data               registered register-file read data
//   i_exmem_valid/_regwrite  EX/MEM producer qualifiers
//   i_exmem_rd/_result       EX/MEM destination and result
//   i_memwb_valid/_regwrite  MEM/WB producer qualifiers
//   i_memwb_rd/_result       MEM/WB destination and writeback data
//   o_data                   forwarded operand
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int R = R_DEF
) (
    input  logic         i_used,
    input  logic [R-1:0] i_src,
    input  logic [N-1:0] i_reg_data,
    input  logic         i_exmem_valid,
    input  logic         i_exmem_regwrite,
    input  logic [R-1:0] i_exmem_rd,
    input  logic [N-1:0] i_exmem_result,
    input  logic         i_memwb_valid,
    input  logic         i_memwb_regwrite,
    input  logic [R-1:0] i_memwb_rd,
    input  logic [N-1:0] i_memwb_result,
    output logic [N-1:0] o_data
);

    logic w_hit_exmem;
    logic w_hit_memwb;

    // R0 is an ordinary register, so a specifier of 0 can match too.
    assign w_hit_exmem = i_used & i_exmem_valid & i_exmem_regwrite & (i_exmem_rd == i_src);
    assign w_hit_memwb = i_used & i_memwb_valid & i_memwb_regwrite & (i_memwb_rd == i_src);

    // EX/MEM is the younger producer and takes precedence.
    always_comb begin
        o_data = i_reg_data;
        if (w_hit_exmem) begin
            o_data = i_exmem_result;
        end else if (w_hit_memwb) begin
            o_data = i_memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding and load-use detect
// Purpose: capture decoded operands, forward younger results into the ALU
//          operands, and insert bubbles on load-use hazards and flushes.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   stall, flush            hold stage / squash stage (flush wins)
//   in_*                    decoded instruction, operands and control from ID
//   exmem_*, memwb_*        forwarding sources
//   ex_*                    registered instruction, forwarded operands, control
//   load_use                hazard: upstream must hold IF/ID this cycle
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int             N   = N_DEF,
    parameter int             R   = R_DEF,
    parameter logic [N-1:0]   NOP = NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [N-1:0] in_instr,
    input  logic [N-1:0] in_rs_data,
    input  logic [N-1:0] in_rt_data,
    input  logic [N-1:0] in_imm,
    input  logic [R-1:0] in_rs,
    input  logic [R-1:0] in_rt,
    input  logic [R-1:0] in_rd,
    input  logic         in_rs_used,
    input  logic         in_rt_used,
    input  logic         in_use_imm,
    input  logic         in_regwrite,
    input  logic         in_memread,
    input  logic         in_memwrite,
    input  logic         exmem_valid,
    input  logic         exmem_regwrite,
    input  logic [R-1:0] exmem_rd,
    input  logic [N-1:0] exmem_result,
    input  logic         memwb_valid,
    input  logic         memwb_regwrite,
    input  logic [R-1:0] memwb_rd,
    input  logic [N-1:0] memwb_result,
    output logic         ex_valid,
    output logic [N-1:0] ex_instr,
    output logic [N-1:0] ex_a,
    output logic [N-1:0] ex_b,
    output logic [N-1:0] ex_store_data,
    output logic [R-1:0] ex_rd,
    output logic         ex_regwrite,
    output logic         ex_memread,
    output logic         ex_memwrite,
    output logic         load_use
);

    logic         r_valid;
    logic [N-1:0] r_instr;
    logic [N-1:0] r_rs_data;
    logic [N-1:0] r_rt_data;
    logic [N-1:0] r_imm;
    logic [R-1:0] r_rs;
    logic [R-1:0] r_rt;
    logic [R-1:0] r_rd;
    logic         r_rs_used;
    logic         r_rt_used;
    logic         r_use_imm;
    logic         r_regwrite;
    logic         r_memread;
    logic         r_memwrite;

    logic         w_load_use;
    logic         w_bubble;
    logic [N-1:0] w_fwd_rs;
    logic [N-1:0] w_fwd_rt;

    // A load in EX cannot forward its data until MEM, so a dependent
    // instruction in ID must wait one cycle.
    assign w_load_use = r_valid & r_memread & in_valid &
                        ((in_rs_used & (in_rs == r_rd)) | (in_rt_used & (in_rt == r_rd)));

    // Flush overrides stall; a load-use bubble only happens when not stalled.
    assign w_bubble = flush | (~stall & w_load_use);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_rs_used  <= 1'b0;
            r_rt_used  <= 1'b0;
            r_use_imm  <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
        end else if (w_bubble) begin
            // Operand fields are left as they are; a bubble never commits.
            r_valid    <= 1'b0;
            r_instr    <= NOP;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
        end else if (!stall) begin
            r_valid    <= in_valid;
            r_instr    <= in_instr;
            r_rs_data  <= in_rs_data;
            r_rt_data  <= in_rt_data;
            r_imm      <= in_imm;
            r_rs       <= in_rs;
            r_rt       <= in_rt;
            r_rd       <= in_rd;
            r_rs_used  <= in_rs_used;
            r_rt_used  <= in_rt_used;
            r_use_imm  <= in_use_imm;
            r_regwrite <= in_valid & in_regwrite;
            r_memread  <= in_valid & in_memread;
            r_memwrite <= in_valid & in_memwrite;
        end
    end

    fwd_mux #(.N(N), .R(R)) u_fwd_rs (
        .i_used           (r_rs_used),
        .i_src            (r_rs),
        .i_reg_data       (r_rs_data),
        .i_exmem_valid    (exmem_valid),
        .i_exmem_regwrite (exmem_regwrite),
        .i_exmem_rd       (exmem_rd),
        .i_exmem_result   (exmem_result),
        .i_memwb_valid    (memwb_valid),
        .i_memwb_regwrite (memwb_regwrite),
        .i_memwb_rd       (memwb_rd),
        .i_memwb_result   (memwb_result),
        .o_data           (w_fwd_rs)
    );

    fwd_mux #(.N(N), .R(R)) u_fwd_rt (
        .i_used           (r_rt_used),
        .i_src            (r_rt),
        .i_reg_data       (r_rt_data),
        .i_exmem_valid    (exmem_valid),
        .i_exmem_regwrite (exmem_regwrite),
        .i_exmem_rd       (exmem_rd),
        .i_exmem_result   (exmem_result),
        .i_memwb_valid    (memwb_valid),
        .i_memwb_regwrite (memwb_regwrite),
        .i_memwb_rd       (memwb_rd),
        .i_memwb_result   (memwb_result),
        .o_data           (w_fwd_rt)
    );

    assign ex_valid      = r_valid;
    assign ex_instr      = r_instr;
    assign ex_a          = w_fwd_rs;
    assign ex_b          = r_use_imm ? r_imm : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;
    assign ex_rd         = r_rd;
    assign ex_regwrite   = r_regwrite;
    assign ex_memread    = r_memread;
    assign ex_memwrite   = r_memwrite;
    assign load_use      = w_load_use;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-stage operand forwarding and load-use hazard detection.
- Sits directly upstream of the ALU decode/execute block and drives its A, B and instruction inputs.
- Captures decoded operands each cycle and substitutes newer results from EX/MEM and MEM/WB.
- Inserts bubbles on load-use hazards and on flushes.

Parameters:
- N, 16, datapath and instruction width.
- R, 3, register-specifier width (8 GPRs; R0 is an ordinary register, not hardwired to zero).
- NOP, 16'h0800, bubble instruction encoding (opcode 5'b00001).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  downstream stall: hold all stage state.
- flush  in  1  branch/jump redirect: squash the stage contents.
- in_valid  in  1  ID holds a real instruction.
- in_instr  in  N  decoded instruction word.
- in_rs_data, in_rt_data  in  N  register-file read data.
- in_imm  in  N  sign/zero-extended immediate.
- in_rs, in_rt, in_rd  in  R  source and destination specifiers.
- in_rs_used, in_rt_used  in  1  source actually read by the instruction.
- in_use_imm  in  1  B operand comes from the immediate.
- in_regwrite, in_memread, in_memwrite  in  1  control bits.
- exmem_valid, exmem_regwrite  in  1  EX/MEM producer qualifiers.
- exmem_rd  in  R  EX/MEM destination register.
- exmem_result  in  N  EX/MEM ALU result.
- memwb_valid, memwb_regwrite  in  1  MEM/WB producer qualifiers.
- memwb_rd  in  R  MEM/WB destination register.
- memwb_result  in  N  MEM/WB writeback data.
- ex_valid  out  1  EX holds a real instruction.
- ex_instr  out  N  to ALU instruction input.
- ex_a  out  N  forwarded rs value, to ALU A.
- ex_b  out  N  immediate or forwarded rt value, to ALU B.
- ex_store_data  out  N  forwarded rt value for stores.
- ex_rd  out  R  registered destination.
- ex_regwrite, ex_memread, ex_memwrite  out  1  registered control bits.
- load_use  out  1  hazard detected; upstream must hold IF/ID this cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - ex_valid=0, ex_instr=NOP, ex_rd=0, all control bits 0, all stored data 0.
  - Consequently ex_a, ex_b and ex_store_data read 0 when no forwarding source matches.
- Registered fields: valid, instr, rs_data, rt_data, imm, rs, rt, rd, rs_used, rt_used, use_imm, regwrite, memread, memwrite.
- Per-edge update, in priority order:
  1. flush=1: load a bubble (valid=0, instr=NOP, regwrite/memread/memwrite=0). Flush also overrides stall.
  2. stall=1: hold every field unchanged.
  3. load_use=1: load a bubble. IF/ID holds the consumer, so it re-presents next cycle.
  4. Otherwise: load all in_* fields. When in_valid=0, control bits are forced to 0.
- load_use (combinational) = ex_valid & ex_memread & in_valid & ((in_rs_used & in_rs==ex_rd) | (in_rt_used & in_rt==ex_rd)).
- Forwarding (combinational, applied on the registered operands, evaluated separately for rs and rt):
  - If exmem_valid & exmem_regwrite & exmem_rd==src: use exmem_result.
  - Else if memwb_valid & memwb_regwrite & memwb_rd==src: use memwb_result.
  - Else: use the registered read data.
  - EX/MEM wins over MEM/WB when both match (youngest producer).
  - Forwarding is suppressed when the matching used-bit is 0.
- ex_a = fwd_rs. ex_b = use_imm ? imm : fwd_rt. ex_store_data = fwd_rt.
- Latency: one cycle from in_* to ex_*. Forwarding adds zero cycles.
- Simultaneous flush and load_use: flush wins; the bubble is identical either way.
- Stall while a bubble is held: the bubble persists.
- Reset mid-stall: state clears immediately, without waiting for a clock edge.
- Width: all data is N bits. No arithmetic is performed here.

Decomposition:
- Shared package holds:
  - NOP encoding.
  - Opcode constants (LD 5'b10001, ST 5'b10000, STU 5'b10011).
  - R and N defaults.
- One natural sub-module: fwd_mux. It is instantiated twice (rs, rt) and selects the operand from the register value, EX/MEM and MEM/WB by specifier match.

Test Plan:
- Reset: drive rst_n=0 mid-cycle -> immediately ex_valid=0, ex_instr=16'h0800, ex_a=0, ex_b=0.
- Plain load: ADD, rs=1 (0x0005), rt=2 (0x0003), no producer matches -> next cycle ex_a=0x0005, ex_b=0x0003, ex_valid=1.
- Double match:
  - Setup: EX/MEM rd=1 result 0x00AA and MEM/WB rd=1 result 0x0055, both regwrite.
  - Required: ex_a=0x00AA.
  - With exmem_regwrite=0 instead: ex_a=0x0055.
- Load-use, case 1:
  - Setup: EX holds LD rd=3; ID presents ADD rs=3.
  - Required: load_use=1; the next edge loads a bubble (ex_valid=0, ex_regwrite=0).
  - Following cycle: the ADD is loaded with load_use=0.
- Load-use, case 2: same setup with in_rs_used=0 -> load_use=0.
- Flush: assert flush and stall together while holding a valid SUBI -> ex_valid=0, ex_instr=NOP after the edge.
- Stall: set stall=1 for 3 cycles while in_* changes -> ex_* unchanged; forwarding still tracks changing exmem_result.
